// File: rtl/instr_mem_pkg.sv
// Shared types and sizing helpers for the pipelined instruction memory.
// Sizes derive from the instance parameters through the helpers below.
package instr_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int MIN_LATENCY = 1;
  localparam int MAX_LATENCY = 4;

  function automatic int wordBytes(input int dw);
    return dw / 8;
  endfunction

  function automatic int byteOfsBits(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int idxBits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Byte-lane instruction RAM: one write port, one synchronous
// read-first read port.
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  localparam int WB        = wordBytes(DATA_WIDTH),
  localparam int IW        = idxBits(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IW-1:0]         wIdx,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic [WB-1:0]         wBe,
  input  logic                  re,
  input  logic [IW-1:0]         rIdx,
  output logic [DATA_WIDTH-1:0] rData
);

  logic [WB-1:0][7:0] mem [DEPTH];

  // Read samples the old word when both ports hit the same index.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WB; i++) begin
        if (wBe[i]) mem[wIdx][i] <= wData[8*i +: 8];
      end
    end
    if (re) rData <= mem[rIdx];
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Pipelined instruction memory with byte-enabled loader writes,
// fetch error flags and a post-reset clear sequencer.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    fetch_req,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  output logic                    fetch_valid,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  output logic                    fetch_misaligned,
  output logic                    fetch_oor,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    ready
);

  localparam int WB  = wordBytes(DATA_WIDTH);
  localparam int OFS = byteOfsBits(DATA_WIDTH);
  localparam int IW  = idxBits(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK =
    ADDR_WIDTH'(WB - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
    ADDR_WIDTH'(DEPTH);

  if (READ_LATENCY < MIN_LATENCY ||
      READ_LATENCY > MAX_LATENCY) begin : gBadLat
    $error("READ_LATENCY out of range");
  end

  state_e stateQ, stateD;
  logic [IW-1:0] clrCntQ, clrCntD;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stateQ  <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clrCntQ <= '0;
    end else begin
      stateQ  <= stateD;
      clrCntQ <= clrCntD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    clrCntD = clrCntQ;
    unique case (stateQ)
      ST_CLEAR: begin
        clrCntD = clrCntQ + 1'b1;
        if (clrCntQ == IW'(DEPTH - 1)) stateD = ST_RUN;
      end
      ST_RUN:  ;
      default: ;
    endcase
  end

  assign ready = (stateQ == ST_RUN);

  // Range checks use the whole address so large addresses never alias.
  logic          fMis, fOor, wOor, fAcc, rdEn;
  logic [IW-1:0] fIdx, wIdx;

  assign fMis = |(fetch_addr & OFS_MASK);
  assign fOor = (fetch_addr >> OFS) >= DEPTH_A;
  assign wOor = (wr_addr >> OFS) >= DEPTH_A;
  assign fIdx = fetch_addr[OFS +: IW];
  assign wIdx = wr_addr[OFS +: IW];
  assign fAcc = fetch_req && ready;
  assign rdEn = fAcc && !fMis && !fOor;

  logic                  memWe;
  logic [IW-1:0]         memIdx;
  logic [DATA_WIDTH-1:0] memData;
  logic [WB-1:0]         memBe;

  always_comb begin
    memWe   = 1'b0;
    memIdx  = wIdx;
    memData = wr_data;
    memBe   = wr_be;
    if (stateQ == ST_CLEAR) begin
      memWe   = 1'b1;
      memIdx  = clrCntQ;
      memData = '0;
      memBe   = '1;
    end else if (wr_en && !wOor) begin
      memWe = 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] rData;

  instr_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) uArray (
    .clk  (clk),
    .we   (memWe),
    .wIdx (memIdx),
    .wData(memData),
    .wBe  (memBe),
    .re   (rdEn),
    .rIdx (fIdx),
    .rData(rData)
  );

  logic                  v0Q, m0Q, o0Q;
  logic [DATA_WIDTH-1:0] d0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v0Q <= 1'b0;
      m0Q <= 1'b0;
      o0Q <= 1'b0;
    end else begin
      v0Q <= fAcc;
      m0Q <= fAcc && fMis;
      o0Q <= fAcc && fOor;
    end
  end

  assign d0 = (v0Q && !m0Q && !o0Q) ? rData : '0;

  if (READ_LATENCY == 1) begin : gNoPipe
    assign fetch_valid      = v0Q;
    assign fetch_data       = d0;
    assign fetch_misaligned = m0Q;
    assign fetch_oor        = o0Q;
  end else begin : gPipe
    localparam int N = READ_LATENCY - 1;
    logic [N-1:0]                 vQ, mQ, oQ;
    logic [N-1:0][DATA_WIDTH-1:0] dQ;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        vQ <= '0;
        mQ <= '0;
        oQ <= '0;
        dQ <= '0;
      end else begin
        vQ[0] <= v0Q;
        mQ[0] <= m0Q;
        oQ[0] <= o0Q;
        dQ[0] <= d0;
        for (int i = 1; i < N; i++) begin
          vQ[i] <= vQ[i-1];
          mQ[i] <= mQ[i-1];
          oQ[i] <= oQ[i-1];
          dQ[i] <= dQ[i-1];
        end
      end
    end

    assign fetch_valid      = vQ[N-1];
    assign fetch_data       = dQ[N-1];
    assign fetch_misaligned = mQ[N-1];
    assign fetch_oor        = oQ[N-1];
  end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Bench for instr_mem_pipe: latency-1 and latency-3 instances share
// stimulus; a word-level model predicts every output cycle.
module tb_instr_mem_pipe;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  logic        fv  [2];
  logic [31:0] fd  [2];
  logic        fm  [2];
  logic        fo  [2];
  logic        rdy [2];

  instr_mem_pipe #(.READ_LATENCY(1)) dutA (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fv[0]), .fetch_data(fd[0]),
    .fetch_misaligned(fm[0]), .fetch_oor(fo[0]),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .ready(rdy[0])
  );

  instr_mem_pipe #(.READ_LATENCY(3)) dutB (
    .clk(clk), .reset_n(reset_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_valid(fv[1]), .fetch_data(fd[1]),
    .fetch_misaligned(fm[1]), .fetch_oor(fo[1]),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .ready(rdy[1])
  );

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        m;
    logic        o;
  } exp_t;

  exp_t        q0 [$];
  exp_t        q1 [$];
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;
  int          clrLeft = DEPTH;
  int          checks = 0;
  int          failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Ready is expected DEPTH clock edges after reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) clrLeft <= DEPTH;
    else if (clrLeft > 0) clrLeft <= clrLeft - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, req);
    end
  endtask

  task automatic cmpOne(input int d);
    exp_t e;
    logic hit;
    hit = 1'b0;
    e = '{-1, 32'd0, 1'b0, 1'b0};
    if (d == 0) begin
      while (q0.size() > 0 && q0[0].cyc < cyc) begin
        void'(q0.pop_front());
        chk("late0", 32'd1, 32'd0);
      end
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        e = q0.pop_front();
        hit = 1'b1;
      end
    end else begin
      while (q1.size() > 0 && q1[0].cyc < cyc) begin
        void'(q1.pop_front());
        chk("late1", 32'd1, 32'd0);
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        hit = 1'b1;
      end
    end
    chk($sformatf("valid%0d", d), 32'(fv[d]), 32'(hit));
    chk($sformatf("data%0d", d), fd[d], e.d);
    chk($sformatf("mis%0d", d), 32'(fm[d]), 32'(e.m));
    chk($sformatf("oor%0d", d), 32'(fo[d]), 32'(e.o));
    chk($sformatf("ready%0d", d), 32'(rdy[d]),
        32'(clrLeft == 0));
  endtask

  always @(negedge clk) begin
    cmpOne(0);
    cmpOne(1);
  end

  // Apply the current inputs to the model, then advance one edge.
  task automatic tick();
    logic        m, o;
    logic [31:0] d;
    if (clrLeft == 0) begin
      if (fetch_req) begin
        m = fetch_addr[1:0] != 2'b00;
        o = fetch_addr >= 32'(DEPTH * 4);
        d = (m || o) ? 32'd0 : mdl[fetch_addr[11:2]];
        q0.push_back('{cyc + 1, d, m, o});
        q1.push_back('{cyc + 3, d, m, o});
      end
      if (wr_en && wr_addr < 32'(DEPTH * 4)) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b])
            mdl[wr_addr[11:2]][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetch_req  = 1'b0;
    fetch_addr = 32'd0;
    wr_en      = 1'b0;
    wr_addr    = 32'd0;
    wr_data    = 32'd0;
    wr_be      = 4'd0;
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    idle();
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick();
    idle();
  endtask

  task automatic doFetch(input logic [31:0] a);
    idle();
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    idle();
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    foreach (mdl[i]) mdl[i] = 32'd0;
  endtask

  task automatic waitClear(input string nm);
    repeat (DEPTH - 1) tick();
    @(negedge clk);
    chk({nm, "_busyA"}, 32'(rdy[0]), 32'd0);
    chk({nm, "_busyB"}, 32'(rdy[1]), 32'd0);
    tick();
    @(negedge clk);
    chk({nm, "_doneA"}, 32'(rdy[0]), 32'd1);
    chk({nm, "_doneB"}, 32'(rdy[1]), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running required=done", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    foreach (mdl[i]) mdl[i] = 32'd0;
    repeat (3) tick();
    chk("rst_valid", 32'(fv[0]), 32'd0);
    chk("rst_ready", 32'(rdy[1]), 32'd0);
    reset_n = 1'b1;

    // Requests during clear must be ignored.
    wr_en      = 1'b1;
    wr_addr    = 32'h0;
    wr_data    = 32'hFFFF_FFFF;
    wr_be      = 4'hF;
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    tick();
    idle();
    repeat (DEPTH - 2) tick();
    @(negedge clk);
    chk("clr_busyA", 32'(rdy[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("clr_doneA", 32'(rdy[0]), 32'd1);
    chk("clr_doneB", 32'(rdy[1]), 32'd1);

    doFetch(32'h14);
    @(negedge clk);
    chk("zero_v", 32'(fv[0]), 32'd1);
    chk("zero_d", fd[0], 32'h0);

    doWrite(32'h14, 32'h0000_0014, 4'hF);
    doFetch(32'h14);
    @(negedge clk);
    chk("wr_rd", fd[0], 32'h0000_0014);

    doFetch(32'h0);
    @(negedge clk);
    chk("clr_wr_ign", fd[0], 32'h0);

    doWrite(32'h20, 32'hAABB_CCDD, 4'hF);
    doWrite(32'h20, 32'h1122_3344, 4'b0101);
    doFetch(32'h20);
    @(negedge clk);
    chk("byte_en", fd[0], 32'hAA22_CC44);

    idle();
    wr_en      = 1'b1;
    wr_addr    = 32'h20;
    wr_data    = 32'hDEAD_BEEF;
    wr_be      = 4'hF;
    fetch_req  = 1'b1;
    fetch_addr = 32'h20;
    tick();
    idle();
    @(negedge clk);
    chk("rdw_old", fd[0], 32'hAA22_CC44);
    fetch_req  = 1'b1;
    fetch_addr = 32'h20;
    tick();
    idle();
    @(negedge clk);
    chk("rdw_new", fd[0], 32'hDEAD_BEEF);

    doFetch(32'h15);
    @(negedge clk);
    chk("mis_flag", 32'(fm[0]), 32'd1);
    chk("mis_data", fd[0], 32'h0);

    doFetch(32'h1000);
    @(negedge clk);
    chk("oor_flag", 32'(fo[0]), 32'd1);
    chk("oor_data", fd[0], 32'h0);

    doFetch(32'h1001);
    @(negedge clk);
    chk("both_flags", {30'd0, fm[0], fo[0]}, 32'd3);

    doFetch(32'hFFFF_FFFC);
    @(negedge clk);
    chk("oor_nowrap", 32'(fo[0]), 32'd1);

    doWrite(32'h1000, 32'hFFFF_FFFF, 4'hF);
    doFetch(32'h0);
    @(negedge clk);
    chk("oor_wr_drop", fd[0], 32'h0);

    doWrite(32'h33, 32'h1234_5678, 4'hF);
    doFetch(32'h30);
    @(negedge clk);
    chk("wr_mask", fd[0], 32'h1234_5678);

    doWrite(32'h0, 32'd1, 4'hF);
    doWrite(32'h4, 32'd2, 4'hF);
    doWrite(32'h8, 32'd3, 4'hF);
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    tick();
    fetch_addr = 32'h4;
    tick();
    fetch_addr = 32'h8;
    tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("pipe_v", 32'(fv[1]), 32'd1);
      chk("pipe_d", fd[1], 32'(k));
      tick();
    end
    @(negedge clk);
    chk("pipe_end", 32'(fv[1]), 32'd0);

    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    tick();
    fetch_addr = 32'h8;
    tick();
    idle();
    doReset();
    chk("flush_vA", 32'(fv[0]), 32'd0);
    chk("flush_dA", fd[0], 32'h0);
    chk("flush_vB", 32'(fv[1]), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (500) tick();
    doReset();
    chk("mid_rdy", 32'(rdy[0]), 32'd0);
    chk("mid_v", 32'(fv[1]), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    waitClear("re_clr");

    doFetch(32'h20);
    @(negedge clk);
    chk("post_clr", fd[0], 32'h0);

    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_pipe.md
Name: instr_mem_pipe

Overview:
- Parametrised, pipelined instruction memory for the CPU fetch path. Successor to the fixed 32-bit single-port instruction memory.
- Adds configurable width, depth and read latency, plus byte-enabled writes for the program loader.
- Flags misaligned and out-of-range fetch addresses, and has a post-reset clear sequencer that gates both ports until the memory is zeroed.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits; multiple of 8.
- DEPTH, 1024, number of words; power of 2.
- ADDR_WIDTH, 32, byte-address width of both ports.
- READ_LATENCY, 1, cycles from accepted fetch to fetch_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, when 1 the memory is zeroed after reset; when 0 the ports are ready immediately.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_req  in  1  fetch request, accepted when fetch_req && ready
- fetch_addr  in  ADDR_WIDTH  byte address of the instruction
- fetch_valid  out  1  fetch_data, fetch_misaligned and fetch_oor are valid this cycle
- fetch_data  out  DATA_WIDTH  instruction word
- fetch_misaligned  out  1  the accepted address was not word-aligned
- fetch_oor  out  1  the accepted word index was >= DEPTH
- wr_en  in  1  write request, accepted when wr_en && ready
- wr_addr  in  ADDR_WIDTH  byte address of the write; low bits ignored
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables; bit i enables byte lane i
- ready  out  1  both ports accept requests

Behaviour:
- Reset (reset_n low, asynchronous):
  - fetch_valid=0, fetch_data=0, fetch_misaligned=0, fetch_oor=0.
  - All latency pipeline stages are cleared to invalid.
  - ready=0 if CLEAR_ON_RESET=1, else ready=1.
  - Memory contents are not touched by reset itself.
- State machine: CLEAR -> RUN.
  - CLEAR: clear counter runs 0..DEPTH-1 and writes one zero word per cycle. ready=0. fetch_req and wr_en are ignored.
  - CLEAR exits to RUN on the cycle after counter DEPTH-1 is written, so ready rises DEPTH cycles after reset_n deasserts.
  - RUN: ready=1. Stays in RUN until reset.
  - CLEAR_ON_RESET=0: reset places the block directly in RUN.
  - reset_n asserted mid-CLEAR restarts the clear from word 0.
- Addressing:
  - word index = addr >> log2(DATA_WIDTH/8).
  - misaligned = any of the low log2(DATA_WIDTH/8) address bits set.
  - oor = word index >= DEPTH, evaluated on the full ADDR_WIDTH address with no wrap-around.
- Fetch:
  - An accepted fetch produces fetch_valid exactly READ_LATENCY cycles later.
  - Fully pipelined: one fetch per cycle, with no bubbles between back-to-back fetches.
  - Misaligned or oor fetch: fetch_data=0 with the matching flag set; memory is not read. If both conditions hold, both flags are set.
  - While fetch_valid=0, fetch_data and both flags hold 0.
- Write:
  - Single-cycle write of the enabled byte lanes; disabled lanes keep their old value.
  - Write to an oor index is dropped silently.
  - Write address misalignment is ignored (low bits masked).
- Simultaneous fetch and write to the same word in one cycle: read-first. The fetch returns the pre-write value, and a fetch accepted the next cycle sees the new value.
- No backpressure on the fetch output. The consumer must take fetch_valid when it is asserted.

Decomposition:
- Shared package (instr_mem_pkg):
  - WORD_BYTES = DATA_WIDTH/8
  - BYTE_OFS_BITS = log2(WORD_BYTES)
  - IDX_BITS = log2(DEPTH)
  - state encoding ST_CLEAR / ST_RUN
  - legal READ_LATENCY bounds
- One sub-module: instr_mem_array. It holds the byte-lane RAM with one write port and one synchronous read port in read-first mode.
- The top level holds the FSM, the clear counter, address decode and the (READ_LATENCY-1)-stage valid/data/flag pipeline.

Test Plan:
- Clear then basic read/write, defaults (DEPTH=1024, READ_LATENCY=1):
  - Release reset -> ready=0 for exactly 1024 cycles, then 1.
  - Fetch addr 0x14 -> fetch_data=0.
  - Write addr 0x14 data 0x00000014 be=4'hF, then fetch 0x14 -> fetch_valid one cycle later with data 0x00000014.
- Byte enables:
  - Write 0x20 data 0xAABBCCDD be=4'hF, then write 0x20 data 0x11223344 be=4'b0101.
  - Fetch 0x20 -> 0xAA22CC44.
- Read-during-write:
  - Word 0x20 holds 0xAA22CC44. Same cycle: write 0x20 data 0xDEADBEEF be=4'hF and fetch 0x20 -> returns 0xAA22CC44.
  - Fetch 0x20 on the next cycle -> returns 0xDEADBEEF.
- Error flags:
  - Fetch 0x15 -> fetch_misaligned=1, data 0.
  - Fetch 0x1000 (index 1024) -> fetch_oor=1, data 0.
  - Write to 0x1000, then fetch 0x0 -> word 0 is unchanged.
- Pipelining, READ_LATENCY=3:
  - Fetch 0x0, 0x4, 0x8 on consecutive cycles, with words preloaded as 1, 2, 3.
  - fetch_valid is high for three consecutive cycles starting 3 cycles after the first request, with data 1, 2, 3 in order.
- Reset mid-operation:
  - Assert reset_n low mid-CLEAR at counter 500 -> outputs go to 0 immediately, and ready rises 1024 cycles after release.
  - Assert reset_n low with fetches in flight -> no fetch_valid appears after reset.
